bcd_7seg_scan_driver: RTL and testbench
=======================================

// Module: bcd_7seg_scan_driver
// PURPOSE
//  Downstream of the binary-to-BCD converter: takes packed BCD digits (ones..thousands) and
//  time-multiplexes them onto a common-anode 7-segment display (active-low seg/an/dp).
//  Double-buffered load, refresh prescaler, one-cycle anti-ghosting dead time, frame pulse.
// PARAMETERS
//  DIGITS     4   number of display digits; digit 0 = rightmost (ones), drives an[0]
//  DIV_WIDTH  17  prescaler width; one scan step every 2**DIV_WIDTH clk cycles
// PORTS
//  clk           in   1         system clock, all state on rising edge
//  reset         in   1         asynchronous, active-high reset
//  bcd_in        in   4*DIGITS  packed BCD, bcd_in[3:0] = digit 0
//  dp_in         in   DIGITS    decimal-point enables, bit i = digit i, 1 = lit
//  load          in   1         capture bcd_in/dp_in into pending buffer this cycle
//  load_pending  out  1         pending buffer not yet applied to display
//  frame_done    out  1         1-cycle pulse at each frame boundary
//  an            out  DIGITS    anode enables, active low
//  seg           out  7         segments {g,f,e,d,c,b,a}, active low
//  dp_n          out  1         decimal point, active low
// BEHAVIOUR
//  Reset (async): div_cnt=0, idx=0, active/pending buffers=0, load_pending=0, frame_done=0,
//   an=all 1s, seg=7'h7F, dp_n=1. Outputs update on the first rising edge after reset releases.
//  Prescaler: div_cnt increments every clk and wraps; tick = (div_cnt == all 1s), one cycle.
//  Index: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1. Boundary = tick while idx==DIGITS-1.
//  Load: load=1 -> pending <= {bcd_in,dp_in}, load_pending <= 1. Last load before boundary wins.
//  Boundary: if load_pending, active <= pending (value before this edge), load_pending <= 0;
//   frame_done <= 1 for one cycle. With load on the boundary cycle, active takes the old
//   pending, pending takes the new data, load_pending stays 1 (applied at next boundary).
//  Load with load_pending=0 at a boundary: active unchanged.
//  Outputs are registered. On a tick cycle: an <= all 1s, seg <= 7'h7F, dp_n <= 1 (dead time).
//   Other cycles: an <= ~(1<<idx), seg <= decode(active digit idx), dp_n <= ~active_dp[idx].
//   Latency: new idx is visible on an/seg one cycle after the tick (that cycle is the dead time).
//  Decode (seg, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000; codes 10-15 -> dash 0111111.
//  Frame period = DIGITS * 2**DIV_WIDTH cycles. Changing active data never tears a frame.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digit i>0 shows seg=7'h7F when it and all more-significant
//   active digits are 0; digit 0 is never blanked; an still enabled; dp unaffected.
//   A dash (10-15) counts as nonzero. Undefined: every digit is decoded, zeros shown as 0.
// TESTING  (DIV_WIDTH=2, DIGITS=4: tick every 4 cycles, frame 16 cycles)
//  1 reset high mid-frame -> an=4'hF, seg=7'h7F, dp_n=1, load_pending=0 with no clock edge.
//  2 load bcd=16'h1234, dp=4'b0100 -> load_pending=1 until boundary; next frame an=1110 seg=0011001,
//    an=1101 seg=0110000, an=1011 seg=0100100 dp_n=0, an=0111 seg=1111001.
//  3 load 16'h0042 -> LEADING_ZERO_BLANK_EN: digits 3,2 seg=7'h7F; undefined: seg=1000000.
//  4 load 16'h00A0 -> digit 1 seg=0111111; with LEADING_ZERO_BLANK_EN digits 3,2 blank, 0 shows 0.
//  5 load 16'h1111 then 16'h2222 on the boundary cycle -> next frame shows 1111, load_pending=1,
//    frame after shows 2222, then load_pending=0; frame_done pulses once per 16 cycles.
//  6 free run -> every tick followed by exactly one cycle an=4'hF; never two anodes low at once.

Source files
------------

// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver for packed BCD digits (active-low an/seg/dp).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_7seg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int DIV_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic                  load_pending,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [IDX_W-1:0]     idx;
    logic                 tick;
    logic                 boundary;

    logic [4*DIGITS-1:0]  pending_bcd;
    logic [DIGITS-1:0]    pending_dp;
    logic [4*DIGITS-1:0]  active_bcd;
    logic [DIGITS-1:0]    active_dp;

    logic [3:0]           cur_digit;
    logic                 blank_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick      = &div_cnt;
    assign boundary  = tick && (idx == LAST_IDX);
    assign cur_digit = active_bcd[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] upper_zero;

    // upper_zero[i]: digit i and every more-significant active digit are zero
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero & (active_bcd[4*i +: 4] == 4'd0);
            upper_zero[i] = all_zero;
        end
    end

    assign blank_digit = (idx != '0) && upper_zero[idx];
`else
    assign blank_digit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // load is a single-cycle strobe with no back-pressure: it always lands in the pending
    // buffer, and the pending buffer only moves to active at a frame boundary, so a frame
    // is never drawn from two different data sets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_bcd  <= '0;
            pending_dp   <= '0;
            active_bcd   <= '0;
            active_dp    <= '0;
            load_pending <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (boundary && load_pending) begin
                active_bcd <= pending_bcd;
                active_dp  <= pending_dp;
            end
            if (load) begin
                pending_bcd <= bcd_in;
                pending_dp  <= dp_in;
            end
            load_pending <= load | (load_pending & ~boundary);
        end
    end

    // The tick cycle is the dead time: all anodes off while idx moves to the next digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= '1;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else if (tick) begin
            an   <= '1;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(DIGITS'(1) << idx);
            seg  <= blank_digit ? 7'h7F : decode(cur_digit);
            dp_n <= ~active_dp[idx];
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Self-checking bench for bcd_7seg_scan_driver (DIGITS=4, DIV_WIDTH=2: 4-cycle step, 16-cycle frame).
// Expected digit frames go into exp_q; a negedge monitor pops one entry per digit presentation.
module tb_bcd_7seg_scan_driver;

    localparam int DIGITS    = 4;
    localparam int DIV_WIDTH = 2;

    localparam logic [6:0] S0     = 7'b1000000;
    localparam logic [6:0] S1     = 7'b1111001;
    localparam logic [6:0] S2     = 7'b0100100;
    localparam logic [6:0] S3     = 7'b0110000;
    localparam logic [6:0] S4     = 7'b0011001;
    localparam logic [6:0] SDASH  = 7'b0111111;
    localparam logic [6:0] SBLANK = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SZ_HI  = SBLANK;
`else
    localparam logic [6:0] SZ_HI  = S0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic [DIGITS-1:0]   dp_in = '0;
    logic                load = 1'b0;
    logic                load_pending;
    logic                frame_done;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp_n;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    bcd_7seg_scan_driver #(
        .DIGITS    (DIGITS),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bcd_in       (bcd_in),
        .dp_in        (dp_in),
        .load         (load),
        .load_pending (load_pending),
        .frame_done   (frame_done),
        .an           (an),
        .seg          (seg),
        .dp_n         (dp_n)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        chk({"frame_done seen ", name}, frame_done, 1);
    endtask

    task automatic do_load(input logic [15:0] bcd, input logic [3:0] dp);
        bcd_in = bcd;
        dp_in  = dp;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic push_digit(input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_q.push_back({a, s, d});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({"scoreboard drained ", name}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Load mid-frame, confirm pending flag, then wait for the frame that shows it.
    task automatic load_and_apply(input string name, input logic [15:0] bcd, input logic [3:0] dp);
        wait_frame({name, " pre"});
        do_load(bcd, dp);
        chk({"load_pending set ", name}, load_pending, 1);
        wait_frame(name);
        chk({"load_pending clear ", name}, load_pending, 0);
    endtask

    // ---------------- monitor ----------------
    logic [3:0]  prev_an;
    int          run_len;
    bit          first_run;
    int          fd_gap;
    bit          fd_first;
    logic [11:0] exp_word;

    always @(negedge clk) begin
        if (reset) begin
            prev_an   = '1;
            run_len   = 0;
            first_run = 1'b1;
            fd_gap    = 0;
            fd_first  = 1'b1;
        end else begin
            if (an != 4'hF && prev_an == 4'hF && exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                checks++;
                if ({an, seg, dp_n} !== exp_word) begin
                    errors++;
                    $display("FAIL digit: got an=%b seg=%b dp_n=%b, expected an=%b seg=%b dp_n=%b",
                             an, seg, dp_n, exp_word[11:8], exp_word[7:1], exp_word[0]);
                end
            end
            if (an != prev_an) begin
                chk("at most one anode low", (an == 4'hF || $countones(~an) == 1), 1);
                if (!first_run)
                    chk(prev_an == 4'hF ? "dead time length" : "digit on-time length",
                        run_len, (prev_an == 4'hF) ? 1 : 3);
                first_run = 1'b0;
                run_len   = 1;
            end else begin
                run_len++;
            end
            prev_an = an;

            fd_gap++;
            if (frame_done) begin
                if (!fd_first) chk("frame_done period", fd_gap, 16);
                fd_first = 1'b0;
                fd_gap   = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state with no clock edge yet
        #2 reset = 1'b1;
        #1;
        chk("reset an", an, 4'hF);
        chk("reset seg", seg, 7'h7F);
        chk("reset dp_n", dp_n, 1);
        chk("reset load_pending", load_pending, 0);
        chk("reset frame_done", frame_done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1234 with decimal point on digit 2
        load_and_apply("1234", 16'h1234, 4'b0100);
        push_digit(4'b1110, S4, 1'b1);
        push_digit(4'b1101, S3, 1'b1);
        push_digit(4'b1011, S2, 1'b0);
        push_digit(4'b0111, S1, 1'b1);
        drain("1234");

        // Asynchronous reset mid-frame with a load pending
        do_load(16'h5678, 4'hF);
        chk("pending before async reset", load_pending, 1);
        #1 reset = 1'b1;
        #1;
        chk("async reset an", an, 4'hF);
        chk("async reset seg", seg, 7'h7F);
        chk("async reset dp_n", dp_n, 1);
        chk("async reset load_pending", load_pending, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 0042: leading digits zero
        load_and_apply("0042", 16'h0042, 4'b0000);
        push_digit(4'b1110, S2, 1'b1);
        push_digit(4'b1101, S4, 1'b1);
        push_digit(4'b1011, SZ_HI, 1'b1);
        push_digit(4'b0111, SZ_HI, 1'b1);
        drain("0042");

        // 00A0: dash counts as nonzero, digit 0 never blanked
        load_and_apply("00A0", 16'h00A0, 4'b0000);
        push_digit(4'b1110, S0, 1'b1);
        push_digit(4'b1101, SDASH, 1'b1);
        push_digit(4'b1011, SZ_HI, 1'b1);
        push_digit(4'b0111, SZ_HI, 1'b1);
        drain("00A0");

        // 1111 mid-frame, then 2222 exactly on the boundary cycle
        wait_frame("1111 pre");
        do_load(16'h1111, 4'b0000);
        repeat (14) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        chk("boundary aligned with 2222 load", frame_done, 1);
        chk("load_pending held over boundary", load_pending, 1);
        for (int i = 0; i < DIGITS; i++) push_digit(~(4'b0001 << i), S1, 1'b1);
        drain("1111");
        wait_frame("2222");
        chk("load_pending clear 2222", load_pending, 0);
        for (int i = 0; i < DIGITS; i++) push_digit(~(4'b0001 << i), S2, 1'b1);
        drain("2222");

        // Free run: monitor checks dead time, single anode and frame period
        repeat (3) wait_frame("free run");
        chk("free run load_pending idle", load_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
